onchip_memory_dp: RTL and testbench

//  Dual-port Avalon-MM on-chip RAM. Successor to the single-port s1 memory: two independent

---
 rtl/onchip_mem_pkg.sv | 32 +++
 rtl/onchip_memory_dp_if.sv | 29 ++
 rtl/onchip_mem_rdpipe.sv | 75 +++++++
 rtl/onchip_memory_dp.sv | 127 ++++++++++++
 tb/tb_onchip_memory_dp.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/onchip_mem_pkg.sv
// Shared constants and helpers for the dual-port on-chip RAM.
//   be_w()      : byte-enable width for a given data width
//   lane_merge(): per-byte-lane resolution when both ports write one word
//   OOB_DATA    : read data returned for out-of-range addresses
package onchip_mem_pkg;

  localparam int unsigned LANE_W     = 8;
  localparam int unsigned MAX_DATA_W = 1024;

  localparam logic [MAX_DATA_W-1:0] OOB_DATA = '0;

  typedef struct packed {
    logic              en;
    logic [LANE_W-1:0] data;
  } lane_t;

  function automatic int unsigned be_w(input int unsigned data_w);
    return data_w / LANE_W;
  endfunction

  // s1 owns any lane it enables; s2 fills only lanes s1 leaves alone.
  function automatic lane_t lane_merge(input logic              s1_be,
                                       input logic [LANE_W-1:0] s1_d,
                                       input logic              s2_be,
                                       input logic [LANE_W-1:0] s2_d);
    lane_t l;
    l.en   = s1_be | s2_be;
    l.data = s1_be ? s1_d : s2_d;
    return l;
  endfunction

endpackage

// File: rtl/onchip_memory_dp_if.sv
// Avalon-MM slave port bundle for one port of onchip_memory_dp.
//   address/chipselect/read/write/byteenable/writedata : master -> slave
//   waitrequest/readdata/readdatavalid                 : slave  -> master
interface onchip_memory_dp_if #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned BW = onchip_mem_pkg::be_w(DATA_W);

  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              read;
  logic              write;
  logic [BW-1:0]     byteenable;
  logic [DATA_W-1:0] writedata;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport slave (
    input  address, chipselect, read, write, byteenable, writedata,
    output waitrequest, readdata, readdatavalid
  );

  modport master (
    output address, chipselect, read, write, byteenable, writedata,
    input  waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/onchip_mem_rdpipe.sv
// Per-port read return pipeline: turns an accepted read into a readdatavalid
// pulse and presents the RAM word (or zero for out-of-range addresses).
// Config macro: ONCHIP_MEM_OUTREG_EN adds a registered output stage (latency 2).
// Ports:
//   clk, rst_n  : clock, reset (async assert, synchronised release)
//   rd_acc      : read accepted this cycle
//   oob         : accepted read address is beyond DEPTH
//   ram_rdata   : RAM output register, loaded on the accept edge
//   rd_valid    : readdatavalid
//   rd_data     : readdata, holds between pulses, zero after reset
module onchip_mem_rdpipe
  import onchip_mem_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_acc,
  input  logic              oob,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data
);

  logic              vld1_q, vld1_d;
  logic              zero1_q, zero1_d;
  logic [DATA_W-1:0] data1_c;

  // zero1 resets high so readdata reads 0 until the first read returns.
  always_comb begin
    vld1_d  = rd_acc;
    zero1_d = zero1_q;
    if (rd_acc) zero1_d = oob;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld1_q  <= 1'b0;
      zero1_q <= 1'b1;
    end else begin
      vld1_q  <= vld1_d;
      zero1_q <= zero1_d;
    end
  end

  assign data1_c = zero1_q ? DATA_W'(OOB_DATA) : ram_rdata;

`ifdef ONCHIP_MEM_OUTREG_EN
  logic              vld2_q, vld2_d;
  logic [DATA_W-1:0] dout_q, dout_d;

  always_comb begin
    vld2_d = vld1_q;
    dout_d = dout_q;
    if (vld1_q) dout_d = data1_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld2_q <= 1'b0;
      dout_q <= '0;
    end else begin
      vld2_q <= vld2_d;
      dout_q <= dout_d;
    end
  end

  assign rd_valid = vld2_q;
  assign rd_data  = dout_q;
`else
  assign rd_valid = vld1_q;
  assign rd_data  = data1_c;
`endif

endmodule

// File: rtl/onchip_memory_dp.sv
// Dual-port Avalon-MM on-chip RAM (true dual port, byte-lane writes,
// pipelined reads with readdatavalid, read-during-write returns old data).
// Config macro: ONCHIP_MEM_OUTREG_EN -> extra output register, read latency 2.
// Memory contents power up undefined and are never cleared by reset.
// Ports:
//   clk        : single clock for both ports
//   reset_n    : asynchronous active-low reset, release synchronised internally
//   clken      : enable for new accesses
//   reset_req  : high blocks new accesses
//   s1, s2     : Avalon-MM slave ports (onchip_memory_dp_if.slave)
module onchip_memory_dp
  import onchip_mem_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DEPTH  = 10000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clken,
  input  logic                reset_req,
  onchip_memory_dp_if.slave   s1,
  onchip_memory_dp_if.slave   s2
);

  localparam int unsigned BW    = be_w(DATA_W);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];

  // Reset release synchroniser.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_n_int;

  always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= rst_sync_d;
  end

  assign rst_n_int = rst_sync_q[1];

  // Accept decode; a simultaneous read+write is treated as a write only.
  logic             run_c;
  logic             s1_acc_c, s1_wr_c, s1_rd_c, s1_in_c;
  logic             s2_acc_c, s2_wr_c, s2_rd_c, s2_in_c;
  logic [IDX_W-1:0] s1_idx_c, s2_idx_c;

  assign run_c          = clken & ~reset_req;
  assign s1.waitrequest = ~run_c;
  assign s2.waitrequest = ~run_c;

  assign s1_acc_c = s1.chipselect & (s1.read | s1.write) & run_c;
  assign s1_wr_c  = s1_acc_c & s1.write;
  assign s1_rd_c  = s1_acc_c & s1.read & ~s1.write;
  assign s1_in_c  = 32'(s1.address) < DEPTH;
  assign s1_idx_c = IDX_W'(s1.address);

  assign s2_acc_c = s2.chipselect & (s2.read | s2.write) & run_c;
  assign s2_wr_c  = s2_acc_c & s2.write;
  assign s2_rd_c  = s2_acc_c & s2.read & ~s2.write;
  assign s2_in_c  = 32'(s2.address) < DEPTH;
  assign s2_idx_c = IDX_W'(s2.address);

  // Same-address collision folds both writes into the s1 write port.
  logic              wa_en_c, wb_en_c, collide_c;
  logic [BW-1:0]     wa_be_c;
  logic [DATA_W-1:0] wa_data_c;
  lane_t             lane_c;

  always_comb begin
    wa_en_c   = s1_wr_c & s1_in_c;
    wb_en_c   = s2_wr_c & s2_in_c;
    wa_be_c   = s1.byteenable;
    wa_data_c = s1.writedata;
    lane_c    = '0;
    collide_c = wa_en_c & wb_en_c & (s1.address == s2.address);
    if (collide_c) begin
      wb_en_c = 1'b0;
      for (int b = 0; b < int'(BW); b++) begin
        lane_c = lane_merge(s1.byteenable[b], s1.writedata[b*LANE_W +: LANE_W],
                            s2.byteenable[b], s2.writedata[b*LANE_W +: LANE_W]);
        wa_be_c[b]                      = lane_c.en;
        wa_data_c[b*LANE_W +: LANE_W]   = lane_c.data;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < int'(BW); b++) begin
      if (wa_en_c && wa_be_c[b])
        mem[s1_idx_c][b*LANE_W +: LANE_W] <= wa_data_c[b*LANE_W +: LANE_W];
      if (wb_en_c && s2.byteenable[b])
        mem[s2_idx_c][b*LANE_W +: LANE_W] <= s2.writedata[b*LANE_W +: LANE_W];
    end
  end

  // RAM output registers; sampled before this edge's writes land (old data).
  logic [DATA_W-1:0] s1_rdata_q, s2_rdata_q;

  always_ff @(posedge clk) begin
    if (s1_rd_c && s1_in_c) s1_rdata_q <= mem[s1_idx_c];
    if (s2_rd_c && s2_in_c) s2_rdata_q <= mem[s2_idx_c];
  end

  onchip_mem_rdpipe #(.DATA_W(DATA_W)) u_rdpipe_s1 (
    .clk       (clk),
    .rst_n     (rst_n_int),
    .rd_acc    (s1_rd_c),
    .oob       (~s1_in_c),
    .ram_rdata (s1_rdata_q),
    .rd_valid  (s1.readdatavalid),
    .rd_data   (s1.readdata)
  );

  onchip_mem_rdpipe #(.DATA_W(DATA_W)) u_rdpipe_s2 (
    .clk       (clk),
    .rst_n     (rst_n_int),
    .rd_acc    (s2_rd_c),
    .oob       (~s2_in_c),
    .ram_rdata (s2_rdata_q),
    .rd_valid  (s2.readdatavalid),
    .rd_data   (s2.readdata)
  );

endmodule

// File: tb/tb_onchip_memory_dp.sv
// Directed self-checking bench for onchip_memory_dp (both latency builds).
module tb_onchip_memory_dp;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 14;
  localparam int unsigned DEPTH  = 10000;
`ifdef ONCHIP_MEM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic clken = 1'b1;
  logic reset_req = 1'b0;
  always #5 clk = ~clk;

  onchip_memory_dp_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1 ();
  onchip_memory_dp_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m2 ();

  onchip_memory_dp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .clken(clken), .reset_req(reset_req),
    .s1(m1), .s2(m2)
  );

  typedef struct { int cyc; logic [31:0] data; } pulse_t;
  pulse_t q1[$];
  pulse_t q2[$];
  int cyc  = 0;
  int nvec = 0;
  int nerr = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (m1.readdatavalid === 1'b1) q1.push_back('{cyc, m1.readdata});
    if (m2.readdatavalid === 1'b1) q2.push_back('{cyc, m2.readdata});
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drv1(input logic rd, input logic wr, input logic [13:0] a,
                      input logic [31:0] d, input logic [3:0] be);
    m1.chipselect = rd | wr; m1.read = rd; m1.write = wr;
    m1.address = a; m1.writedata = d; m1.byteenable = be;
  endtask

  task automatic drv2(input logic rd, input logic wr, input logic [13:0] a,
                      input logic [31:0] d, input logic [3:0] be);
    m2.chipselect = rd | wr; m2.read = rd; m2.write = wr;
    m2.address = a; m2.writedata = d; m2.byteenable = be;
  endtask

  task automatic idle();
    drv1(1'b0, 1'b0, '0, '0, '0);
    drv2(1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic test_reset();
    idle(); reset_n = 1'b0; clken = 1'b1; reset_req = 1'b0;
    tick(3);
    nvec++; if (m1.readdatavalid !== 1'b0) begin nerr++; $display("FAIL reset_rdv1 got %b exp 0", m1.readdatavalid); end
    nvec++; if (m2.readdatavalid !== 1'b0) begin nerr++; $display("FAIL reset_rdv2 got %b exp 0", m2.readdatavalid); end
    nvec++; if (m1.readdata !== 32'h0) begin nerr++; $display("FAIL reset_rd1 got %h exp 0", m1.readdata); end
    nvec++; if (m2.readdata !== 32'h0) begin nerr++; $display("FAIL reset_rd2 got %h exp 0", m2.readdata); end
    nvec++; if (m1.waitrequest !== 1'b0) begin nerr++; $display("FAIL wait_run got %b exp 0", m1.waitrequest); end
    reset_req = 1'b1; #1;
    nvec++; if (m2.waitrequest !== 1'b1) begin nerr++; $display("FAIL wait_rreq got %b exp 1", m2.waitrequest); end
    reset_req = 1'b0; clken = 1'b0; #1;
    nvec++; if (m1.waitrequest !== 1'b1) begin nerr++; $display("FAIL wait_clken got %b exp 1", m1.waitrequest); end
    clken = 1'b1;
    reset_n = 1'b1;
    tick(4);
    q1.delete(); q2.delete();
  endtask

  task automatic test_write_read();
    int acc;
    q1.delete(); q2.delete();
    drv1(1'b0, 1'b1, 14'h10, 32'hDEADBEEF, 4'hF); tick(1);
    idle(); drv2(1'b1, 1'b0, 14'h10, '0, '0); tick(1); acc = cyc;
    idle(); tick(4);
    nvec++; if (q2.size() != 1) begin nerr++; $display("FAIL wr_rd_count got %0d exp 1", q2.size()); end
    else begin
      nvec++; if (q2[0].data !== 32'hDEADBEEF) begin nerr++; $display("FAIL wr_rd_data got %h exp deadbeef", q2[0].data); end
      nvec++; if (q2[0].cyc != acc + LAT - 1) begin nerr++; $display("FAIL wr_rd_latency got %0d exp %0d", q2[0].cyc, acc + LAT - 1); end
    end
    nvec++; if (m2.readdata !== 32'hDEADBEEF) begin nerr++; $display("FAIL rd_hold got %h exp deadbeef", m2.readdata); end
    nvec++; if (q1.size() != 0) begin nerr++; $display("FAIL write_no_valid got %0d exp 0", q1.size()); end
  endtask

  task automatic test_collision();
    logic [31:0] exp1 [4];
    exp1 = '{32'h5566CCDD, 32'hA102C304, 32'h12345678, 32'h00000001};
    drv1(1'b0, 1'b1, 14'd5, 32'h11223344, 4'hF); tick(1);
    drv1(1'b0, 1'b1, 14'd5, 32'hAABBCCDD, 4'b0011);
    drv2(1'b0, 1'b1, 14'd5, 32'h55667788, 4'b1111); tick(1);
    drv1(1'b0, 1'b1, 14'h40, 32'hA1B2C3D4, 4'b1010);
    drv2(1'b0, 1'b1, 14'h40, 32'h01020304, 4'b0101); tick(1);
    drv1(1'b0, 1'b1, 14'h41, 32'h12345678, 4'hF);
    drv2(1'b0, 1'b1, 14'h41, 32'h9ABCDEF0, 4'hF); tick(1);
    drv1(1'b0, 1'b1, 14'h42, 32'h00000001, 4'hF);
    drv2(1'b0, 1'b1, 14'h43, 32'h00000002, 4'hF); tick(1);
    idle(); q1.delete(); q2.delete();
    drv1(1'b1, 1'b0, 14'd5, '0, '0); tick(1);
    drv1(1'b1, 1'b0, 14'h40, '0, '0); tick(1);
    drv1(1'b1, 1'b0, 14'h41, '0, '0); tick(1);
    drv1(1'b1, 1'b0, 14'h42, '0, '0); drv2(1'b1, 1'b0, 14'h43, '0, '0); tick(1);
    idle(); tick(4);
    nvec++; if (q1.size() != 4) begin nerr++; $display("FAIL coll_count got %0d exp 4", q1.size()); end
    for (int i = 0; i < q1.size() && i < 4; i++) begin
      nvec++; if (q1[i].data !== exp1[i]) begin nerr++; $display("FAIL coll_data%0d got %h exp %h", i, q1[i].data, exp1[i]); end
    end
    nvec++; if (q2.size() != 1) begin nerr++; $display("FAIL par_count got %0d exp 1", q2.size()); end
    else begin
      nvec++; if (q2[0].data !== 32'h2) begin nerr++; $display("FAIL par_data got %h exp 2", q2[0].data); end
    end
  endtask

  task automatic test_rdw();
    drv1(1'b0, 1'b1, 14'd7, 32'h1, 4'hF); drv2(1'b0, 1'b1, 14'h50, 32'hAAAA0000, 4'hF); tick(1);
    idle(); q1.delete(); q2.delete();
    drv1(1'b0, 1'b1, 14'd7, 32'h2, 4'hF); drv2(1'b1, 1'b0, 14'd7, '0, '0); tick(1);
    idle(); drv2(1'b1, 1'b0, 14'd7, '0, '0); tick(1);
    drv2(1'b0, 1'b1, 14'h50, 32'h0000BBBB, 4'hF); drv1(1'b1, 1'b0, 14'h50, '0, '0); tick(1);
    idle(); tick(4);
    nvec++; if (q2.size() != 2) begin nerr++; $display("FAIL rdw_count got %0d exp 2", q2.size()); end
    else begin
      nvec++; if (q2[0].data !== 32'h1) begin nerr++; $display("FAIL rdw_old got %h exp 1", q2[0].data); end
      nvec++; if (q2[1].data !== 32'h2) begin nerr++; $display("FAIL rdw_new got %h exp 2", q2[1].data); end
    end
    nvec++; if (q1.size() != 1) begin nerr++; $display("FAIL rdw_x_count got %0d exp 1", q1.size()); end
    else begin
      nvec++; if (q1[0].data !== 32'hAAAA0000) begin nerr++; $display("FAIL rdw_x_old got %h exp aaaa0000", q1[0].data); end
    end
    q1.delete();
    drv1(1'b1, 1'b1, 14'h51, 32'h77, 4'hF); tick(1);
    idle(); tick(4);
    nvec++; if (q1.size() != 0) begin nerr++; $display("FAIL rdwr_drop got %0d exp 0", q1.size()); end
    drv1(1'b1, 1'b0, 14'h51, '0, '0); tick(1);
    idle(); tick(4);
    nvec++; if (q1.size() != 1 || q1[0].data !== 32'h77) begin nerr++; $display("FAIL rdwr_write got %0d pulses exp 1 of 00000077", q1.size()); end
  endtask

  task automatic test_oob();
    logic [31:0] exp1 [4];
    exp1 = '{32'hCAFEF00D, 32'h0, 32'h0BADBEEF, 32'hCAFEF00D};
    drv1(1'b0, 1'b1, 14'd9999, 32'hCAFEF00D, 4'hF); drv2(1'b0, 1'b1, 14'd1808, 32'h0BADBEEF, 4'hF); tick(1);
    drv1(1'b0, 1'b1, 14'd10000, 32'hFFFFFFFF, 4'hF); drv2(1'b0, 1'b1, 14'd16383, 32'h13572468, 4'hF); tick(1);
    idle(); q1.delete(); q2.delete();
    drv1(1'b1, 1'b0, 14'd9999, '0, '0); tick(1);
    drv1(1'b1, 1'b0, 14'd10000, '0, '0); drv2(1'b1, 1'b0, 14'd16383, '0, '0); tick(1);
    idle(); drv1(1'b1, 1'b0, 14'd1808, '0, '0); tick(1);
    drv1(1'b1, 1'b0, 14'd9999, '0, '0); drv2(1'b1, 1'b0, 14'h10, '0, '0); tick(1);
    idle(); tick(4);
    nvec++; if (q1.size() != 4) begin nerr++; $display("FAIL oob_count got %0d exp 4", q1.size()); end
    for (int i = 0; i < q1.size() && i < 4; i++) begin
      nvec++; if (q1[i].data !== exp1[i]) begin nerr++; $display("FAIL oob_data%0d got %h exp %h", i, q1[i].data, exp1[i]); end
    end
    if (q1.size() > 1) begin
      nvec++; if (q1[1].cyc != q1[0].cyc + 1) begin nerr++; $display("FAIL oob_timing got %0d exp %0d", q1[1].cyc, q1[0].cyc + 1); end
    end
    nvec++; if (q2.size() != 2) begin nerr++; $display("FAIL oob2_count got %0d exp 2", q2.size()); end
    else begin
      nvec++; if (q2[0].data !== 32'h0) begin nerr++; $display("FAIL oob2_zero got %h exp 0", q2[0].data); end
      nvec++; if (q2[1].data !== 32'hDEADBEEF) begin nerr++; $display("FAIL oob2_other got %h exp deadbeef", q2[1].data); end
    end
  endtask

  task automatic test_clken();
    q1.delete(); q2.delete();
    clken = 1'b0;
    drv1(1'b1, 1'b0, 14'h10, '0, '0); drv2(1'b0, 1'b1, 14'h10, 32'h0, 4'hF); #1;
    nvec++; if (m1.waitrequest !== 1'b1) begin nerr++; $display("FAIL clken_wait got %b exp 1", m1.waitrequest); end
    tick(1);
    clken = 1'b1; idle(); tick(4);
    nvec++; if (q1.size() != 0) begin nerr++; $display("FAIL clken_block got %0d exp 0", q1.size()); end
    drv1(1'b1, 1'b0, 14'h10, '0, '0); tick(1);
    idle(); tick(4);
    nvec++; if (q1.size() != 1 || q1[0].data !== 32'hDEADBEEF) begin nerr++; $display("FAIL clken_nowrite got %0d pulses exp 1 of deadbeef", q1.size()); end
  endtask

  task automatic test_back_to_back();
    int acc0;
    int slot;
    for (int i = 0; i < 8; i++) begin
      drv1(1'b0, 1'b1, 14'(i), 32'h100 + 32'(i), 4'hF); tick(1);
    end
    idle(); q1.delete(); acc0 = 0;
    for (int i = 0; i < 8; i++) begin
      drv1(1'b1, 1'b0, 14'(i), '0, '0);
      reset_req = (i == 3);
      #1;
      nvec++; if (m1.waitrequest !== (i == 3)) begin nerr++; $display("FAIL b2b_wait%0d got %b exp %b", i, m1.waitrequest, (i == 3)); end
      tick(1);
      if (i == 0) acc0 = cyc;
    end
    reset_req = 1'b0; idle(); tick(5);
    nvec++; if (q1.size() != 7) begin nerr++; $display("FAIL b2b_count got %0d exp 7", q1.size()); end
    for (int j = 0; j < q1.size() && j < 7; j++) begin
      slot = (j < 3) ? j : j + 1;
      nvec++; if (q1[j].data !== 32'h100 + 32'(slot)) begin nerr++; $display("FAIL b2b_data%0d got %h exp %h", j, q1[j].data, 32'h100 + 32'(slot)); end
      nvec++; if (q1[j].cyc != acc0 + LAT - 1 + slot) begin nerr++; $display("FAIL b2b_cyc%0d got %0d exp %0d", j, q1[j].cyc, acc0 + LAT - 1 + slot); end
    end
  endtask

  task automatic test_reset_flight();
    drv1(1'b0, 1'b1, 14'h30, 32'h5A5A5A5A, 4'hF); tick(1);
    idle(); q1.delete(); q2.delete();
    drv1(1'b1, 1'b0, 14'h30, '0, '0); drv2(1'b1, 1'b0, 14'h10, '0, '0); tick(1);
    reset_n = 1'b0; idle(); tick(3);
    nvec++; if (m1.readdata !== 32'h0 || m2.readdata !== 32'h0) begin nerr++; $display("FAIL flight_rd0 got %h/%h exp 0/0", m1.readdata, m2.readdata); end
    reset_n = 1'b1; tick(4);
    nvec++; if (q1.size() + q2.size() != 0) begin nerr++; $display("FAIL flight_lost got %0d exp 0", q1.size() + q2.size()); end
    drv1(1'b1, 1'b0, 14'h30, '0, '0); drv2(1'b1, 1'b0, 14'h10, '0, '0); tick(1);
    idle(); tick(4);
    nvec++; if (q1.size() != 1 || q1[0].data !== 32'h5A5A5A5A) begin nerr++; $display("FAIL flight_keep1 got %0d pulses exp 1 of 5a5a5a5a", q1.size()); end
    nvec++; if (q2.size() != 1 || q2[0].data !== 32'hDEADBEEF) begin nerr++; $display("FAIL flight_keep2 got %0d pulses exp 1 of deadbeef", q2.size()); end
  endtask

  initial begin
    idle();
    test_reset();
    test_write_read();
    test_collision();
    test_rdw();
    test_oob();
    test_clken();
    test_back_to_back();
    test_reset_flight();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
